gzip_input_arbiter: RTL and testbench
=====================================

// Module: gzip_input_arbiter
//
// PURPOSE
// - Shares the compressor's single 9-bit input stream among N_REQ requesters. Each beat is
//   {last, byte[7:0]}; data[8]=1 marks the final byte of a file.
// - Grants one requester at a time, round-robin. The grant stays locked until that requester's
//   last beat is accepted, so files never interleave.
// - Output is registered through a 2-entry buffer and feeds the compressor's input FIFO directly.
// - Each output beat carries the source id of the requester that sent it.
//
// PARAMETERS
// - N_REQ  default 4  number of requesters; legal range 2..16
// - SW     default 2  source-id width, = clog2(N_REQ); the instantiating module passes it consistently
//
// PORTS
// Clocking / reset: one clock; reset is synchronous and active-high.
// - clk     in   1          clock; all state changes on the rising edge
// - rst     in   1          synchronous, active-high reset
// - i_en    in   N_REQ      per-requester beat valid
// - i_data  in   N_REQ*9    requester k occupies bits [9k+8:9k]; bit 9k+8 = last
// - i_rdy   out  N_REQ      per-requester accept; a beat transfers when i_en[k] & i_rdy[k]
// - o_rdy   in   1          downstream ready
// - o_en    out  1          output beat valid
// - o_data  out  9          output beat {last, byte}
// - o_src   out  SW         requester index of the current o_data beat
// - busy    out  1          1 while in LOCK state, or while o_en=1
//
// BEHAVIOUR
// Reset
// - Outputs: i_rdy=0, o_en=0, o_data=0, o_src=0, busy=0.
// - State: state=IDLE, gnt=0, last_gnt=N_REQ-1, so that requester 0 has first priority.
// - Asserting rst mid-file drops the partial file and empties the buffer. No recovery beat is emitted.
//
// FSM, two states
// - IDLE:
//   - i_rdy=0 for all requesters.
//   - If any i_en is set, pick the first set index scanning last_gnt+1, last_gnt+2, ... modulo N_REQ.
//   - Register the pick as gnt and go to LOCK.
//   - The decision uses i_en only; no data is consumed in IDLE.
// - LOCK:
//   - i_rdy[gnt] = buffer input ready; all other i_rdy are 0.
//   - An accepted beat with last=1 sets last_gnt=gnt and returns to IDLE next cycle.
//   - Result: one bubble cycle between files.
// - No timeout. If the granted requester drops i_en mid-file, the arbiter stays in LOCK
//   indefinitely; the others wait.
// - A single-beat file (first beat has last=1) gives LOCK for exactly one accept, then IDLE.
// - Non-granted requesters see i_rdy=0 and must hold their data. The arbiter never consumes
//   their beats.
//
// Output buffer (2 entries, 9+SW bits each)
// - Latency: a beat accepted at edge t is visible on o_en/o_data/o_src after edge t, i.e. 1 cycle.
// - Input ready = buffer not full. Full throughput: 1 beat/clk with o_rdy held at 1.
// - Simultaneous push and pop while holding one entry: entry replaced, count unchanged.
// - Push while full never occurs (i_rdy=0). Pop while empty is ignored.
// - While o_en=1 and o_rdy=0, o_data and o_src must hold stable.
// - Beat order is preserved; o_src always equals the grant that was active when the beat was accepted.
//
// STRUCTURE
// - Shared header gzip_defs.vh: IN_DW=9, IN_LAST_BIT=8. No other shared constants.
// - Sub-module fifo2_tagged: 2-entry ready/valid buffer.
//   - Payload = {src, data}; generic width parameter.
//   - Synchronous active-high reset.
// - Top level contains the FSM, the round-robin picker (rotate, priority-encode, un-rotate)
//   and the i_rdy demux.
//
// TESTING
// 1. Single requester. Stream 0x41,0x42,0x143 on req 2, o_rdy=1.
//    -> o_data 0x041,0x042,0x143, o_src=2 each; IDLE one cycle after the last accept.
// 2. Round-robin. All four requesters present a 2-beat file from reset.
//    -> grant order 0,1,2,3; no interleaving; exactly one idle cycle between files.
// 3. Fairness. Req 0 and req 1 continuously present files.
//    -> grants alternate 0,1,0,1; req 0 never wins twice in a row.
// 4. Backpressure. o_rdy toggles 1,0,0,1 during a 5-beat file.
//    -> o_data/o_src stable while stalled; no beat lost or duplicated; max 2 beats buffered.
// 5. Stall and idle behaviour.
//    - Granted req 1 drops i_en for 10 cycles mid-file while req 3 waits
//      -> i_rdy[3]=0 throughout; req 1 resumes and finishes first.
//    - Single-beat file 0x1FF on req 0 -> one LOCK cycle, o_data=0x1FF.
// 6. Reset mid-file. Assert rst for 1 cycle after 2 beats of a 4-beat file.
//    -> o_en=0 and all i_rdy=0 next cycle; next grant goes to req 0 if requesting.

Source files
------------

// File: rtl/gzip_input_arbiter_pkg.sv
// Shared constants and types for the gzip input arbiter.
// A beat is {last, byte}; the last flag sits in the top bit.
package gzip_input_arbiter_pkg;

    localparam int IN_DW       = 9;
    localparam int IN_LAST_BIT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/gzip_input_arbiter_if.sv
// Requester-side and compressor-side handshake bundle for the gzip input arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface gzip_input_arbiter_if
    import gzip_input_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SW    = 2
);

    logic [N_REQ-1:0]       i_en;
    logic [N_REQ*IN_DW-1:0] i_data;
    logic [N_REQ-1:0]       i_rdy;
    logic                   o_rdy;
    logic                   o_en;
    logic [IN_DW-1:0]       o_data;
    logic [SW-1:0]          o_src;
    logic                   busy;

    modport slave (
        input  i_en, i_data, o_rdy,
        output i_rdy, o_en, o_data, o_src, busy
    );

    modport master (
        output i_en, i_data, o_rdy,
        input  i_rdy, o_en, o_data, o_src, busy
    );

endinterface

// File: rtl/gzip_input_arbiter_fifo2_tagged.sv
// Two-entry ready/valid buffer carrying a {src, data} payload.
// Outputs come straight from registers, so a pushed beat appears one cycle later.
module fifo2_tagged #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_en,
    input  logic [W-1:0] in_data,
    output logic         in_rdy,
    output logic         out_en,
    output logic [W-1:0] out_data,
    input  logic         out_rdy
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_rdy   = (count != 2'd2);
    assign out_en   = (count != 2'd0);
    assign out_data = mem[rd_ptr];
    assign push     = in_en & in_rdy;
    assign pop      = out_en & out_rdy;

    // Entries are cleared on reset so the output bus reads zero until the first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gzip_input_arbiter.sv
// Round-robin arbiter sharing the compressor input among N_REQ requesters.
// A grant is held until the requester's last beat is accepted, so files never interleave.
module gzip_input_arbiter
    import gzip_input_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SW    = 2
) (
    input logic                clk,
    input logic                rst,
    gzip_input_arbiter_if.slave bus
);

    arb_state_t            state;
    logic [SW-1:0]         gnt;
    logic [SW-1:0]         last_gnt;

    logic [2*N_REQ-1:0]    en_twice;
    logic [SW:0]           start;
    logic [N_REQ-1:0]      rot;
    logic [SW-1:0]         offset;
    logic [SW:0]           pick_sum;
    logic [SW-1:0]         pick;

    logic [IN_DW-1:0]      beat;
    logic                  push;
    logic                  buf_in_rdy;
    logic                  buf_out_en;
    logic [SW+IN_DW-1:0]   buf_out;

    // Rotate requests so last_gnt+1 lands at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        en_twice = {bus.i_en, bus.i_en};
        start    = {1'b0, last_gnt} + (SW+1)'(1);
        rot      = N_REQ'(en_twice >> start);
        offset   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = SW'(i);
            end
        end
        pick_sum = start + {1'b0, offset};
        pick     = (pick_sum >= (SW+1)'(N_REQ)) ? SW'(pick_sum - (SW+1)'(N_REQ))
                                                 : SW'(pick_sum);
    end

    assign beat = bus.i_data[IN_DW*gnt +: IN_DW];
    assign push = (state == LOCK) & bus.i_en[gnt] & buf_in_rdy;

    always_comb begin
        bus.i_rdy = '0;
        if (state == LOCK) begin
            bus.i_rdy[gnt] = buf_in_rdy;
        end
    end

    // last_gnt starts at N_REQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= SW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.i_en) begin
                        gnt   <= pick;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (push && beat[IN_LAST_BIT]) begin
                        last_gnt <= gnt;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo2_tagged #(
        .W(SW + IN_DW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_en    (push),
        .in_data  ({gnt, beat}),
        .in_rdy   (buf_in_rdy),
        .out_en   (buf_out_en),
        .out_data (buf_out),
        .out_rdy  (bus.o_rdy)
    );

    assign bus.o_en   = buf_out_en;
    assign bus.o_data = buf_out[IN_DW-1:0];
    assign bus.o_src  = buf_out[IN_DW +: SW];
    assign bus.busy   = (state == LOCK) | buf_out_en;

endmodule

// File: tb/tb_gzip_input_arbiter.sv
// Scoreboard bench for gzip_input_arbiter: requester queues feed the DUT,
// expected {src, beat} words are queued at issue time and popped by a monitor.
module tb_gzip_input_arbiter;

    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gzip_input_arbiter_if #(.N_REQ(N), .SW(SW)) bus ();

    gzip_input_arbiter #(.N_REQ(N), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0]    req_q [N][$];
    int            sent_cnt [N] = '{default: 0};
    int            hold_at  [N] = '{default: -1};
    int            hold_len [N] = '{default: 0};
    logic [SW+8:0] exp_q [$];
    int            pop_cyc [$];

    logic       rdy_mode  = 1'b0;
    logic       rdy_level = 1'b1;
    logic [3:0] rdy_pat   = 4'b1001;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Requester models: present the queue head, retire it when the handshake fires.
    initial begin
        int   pause [N];
        logic fired [N];
        bus.i_en   = '0;
        bus.i_data = '0;
        for (int k = 0; k < N; k++) pause[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) fired[k] = !rst && bus.i_en[k] && bus.i_rdy[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    req_q[k].delete();
                    pause[k] = 0;
                end else if (fired[k]) begin
                    void'(req_q[k].pop_front());
                    sent_cnt[k]++;
                    if (sent_cnt[k] == hold_at[k]) pause[k] = hold_len[k];
                end
                if (rst || pause[k] > 0 || req_q[k].size() == 0) begin
                    bus.i_en[k]          = 1'b0;
                    bus.i_data[k*9 +: 9] = '0;
                    if (pause[k] > 0) pause[k]--;
                end else begin
                    bus.i_en[k]          = 1'b1;
                    bus.i_data[k*9 +: 9] = req_q[k][0];
                end
            end
        end
    end

    initial begin
        int ph = 0;
        bus.o_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                bus.o_rdy = rdy_pat[ph % 4];
                ph++;
            end else begin
                bus.o_rdy = rdy_level;
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stalled outputs hold.
    initial begin
        logic          stalled = 1'b0;
        logic [SW+8:0] held;
        logic [SW+8:0] got;
        logic [SW+8:0] want;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                got = {bus.o_src, bus.o_data};
                if (stalled) checkOutput("stall_hold", 32'(got), 32'(held));
                if (bus.o_en && bus.o_rdy) begin
                    pop_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_beat: got 0x%0h, want none", got);
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("out_beat", 32'(got), 32'(want));
                    end
                    stalled = 1'b0;
                end else if (bus.o_en) begin
                    stalled = 1'b1;
                    held    = got;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        pop_cyc.delete();
        tick(1);
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] first, input int n,
                                 input bit expect_out);
        for (int b = 0; b < n; b++) begin
            logic [8:0] beat;
            beat = {(b == n - 1), 8'(first + b)};
            req_q[k].push_back(beat);
            if (expect_out) exp_q.push_back({SW'(k), beat});
        end
    endtask

    function automatic bit anyPending();
        for (int k = 0; k < N; k++) if (req_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic waitDrain(input string name, input int max_cyc);
        int c = 0;
        while ((exp_q.size() != 0 || anyPending()) && c < max_cyc) begin
            tick(1);
            c++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
        tick(3);
    endtask

    task automatic countRdy(input int k, input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.i_rdy[k]) hits++;
        end
    endtask

    initial begin
        int hits;
        int base;
        int c;

        // Reset state
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        checkOutput("reset_state",
                    32'({bus.i_rdy, bus.o_en, bus.o_data, bus.o_src, bus.busy}), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Single requester stream, lock lasts exactly the three accepts
        resetDut();
        applyStimulus(2, 8'h41, 3, 1'b1);
        countRdy(2, 12, hits);
        checkOutput("single_lock_cycles", 32'(hits), 32'd3);
        waitDrain("single_drain", 50);
        checkOutput("single_idle_busy", 32'(bus.busy), 32'd0);

        // Round-robin from reset with one bubble between files
        resetDut();
        for (int k = 0; k < N; k++) applyStimulus(k, 8'(8'h10 * (k + 1)), 2, 1'b1);
        waitDrain("rr_drain", 100);
        checkOutput("rr_pops", 32'(pop_cyc.size()), 32'd8);
        for (int i = 1; i < pop_cyc.size() && i < 8; i++)
            checkOutput("rr_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), (i % 2 == 1) ? 32'd1 : 32'd2);

        // Fairness between two continuously requesting sources
        resetDut();
        for (int f = 0; f < 3; f++) begin
            applyStimulus(0, 8'(8'h01 + 2*f), 2, 1'b1);
            applyStimulus(1, 8'(8'h81 + 2*f), 2, 1'b1);
        end
        waitDrain("fair_drain", 100);

        // Backpressure with o_rdy cycling 1,0,0,1
        resetDut();
        rdy_mode = 1'b1;
        applyStimulus(2, 8'h50, 5, 1'b1);
        waitDrain("bp_drain", 100);
        rdy_mode = 1'b0;
        tick(2);

        // Granted requester pauses mid-file; the waiting one stays blocked
        resetDut();
        hold_at[1]  = sent_cnt[1] + 2;
        hold_len[1] = 10;
        applyStimulus(1, 8'h20, 4, 1'b1);
        applyStimulus(3, 8'h30, 2, 1'b1);
        c = 0;
        while (req_q[1].size() != 0 && c < 80) begin
            @(negedge clk);
            checkOutput("wait_rdy3", 32'(bus.i_rdy[3]), 32'd0);
            c++;
        end
        waitDrain("stall_drain", 100);
        hold_at[1] = -1;

        // Single-beat file
        resetDut();
        applyStimulus(0, 8'hFF, 1, 1'b1);
        countRdy(0, 8, hits);
        checkOutput("one_beat_lock", 32'(hits), 32'd1);
        waitDrain("one_beat_drain", 50);

        // Reset mid-file drops buffered beats and restores requester 0 priority
        resetDut();
        applyStimulus(0, 8'hA0, 1, 1'b1);
        waitDrain("pre_rst_drain", 50);
        rdy_level = 1'b0;
        tick(1);
        base = sent_cnt[3];
        applyStimulus(3, 8'hC0, 4, 1'b0);
        c = 0;
        while (sent_cnt[3] < base + 2 && c < 50) begin
            tick(1);
            c++;
        end
        checkOutput("mid_file_beats", 32'(sent_cnt[3] - base), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_clears", 32'({bus.o_en, bus.i_rdy, bus.o_data}), 32'd0);
        tick(1);
        rdy_level = 1'b1;
        applyStimulus(0, 8'hE0, 2, 1'b1);
        applyStimulus(1, 8'hF0, 2, 1'b1);
        waitDrain("post_rst_drain", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
